// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - two-requester sequencer driving a shared external ripple-carry adder slice
module rca_seq_ctrl #(
    parameter int OP_W    = 16,
    parameter int SLICE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [OP_W-1:0]    req0_a,
    input  logic [OP_W-1:0]    req0_b,
    input  logic               req0_cin,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [OP_W-1:0]    req1_a,
    input  logic [OP_W-1:0]    req1_b,
    input  logic               req1_cin,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [OP_W-1:0]    res_sum,
    output logic               res_cout,
    output logic               res_id,
    output logic [SLICE_W-1:0] slc_a,
    output logic [SLICE_W-1:0] slc_b,
    output logic               slc_cin,
    input  logic [SLICE_W-1:0] slc_sum,
    input  logic               slc_cout
);

    localparam int NSLICE = OP_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 2) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_carry;
    logic              r_prio;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic              r_id;
    logic [OP_W-1:0]   r_sum;
    logic [OP_W-1:0]   r_res_sum;
    logic              r_res_cout;
    logic              r_res_id;

    logic              w_gnt;
    logic              w_acc;
    logic              w_last;
    logic [OP_W-1:0]   w_sum_nxt;

    // Arbitration: a lone requester wins; on contention the priority pointer decides.
    always_comb begin
        w_gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            w_gnt = r_prio;
        end else if (req1_valid) begin
            w_gnt = 1'b1;
        end
        req0_ready = (r_state == S_IDLE) && req0_valid && !w_gnt;
        req1_ready = (r_state == S_IDLE) && req1_valid &&  w_gnt;
        w_acc      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        w_last     = (r_cnt == CNT_W'(NSLICE - 1));
    end

    // Slice operands are only presented while running; quiet zeros otherwise.
    always_comb begin
        slc_a     = '0;
        slc_b     = '0;
        slc_cin   = 1'b0;
        w_sum_nxt = r_sum;
        if (r_state == S_RUN) begin
            slc_a   = r_a[r_cnt*SLICE_W +: SLICE_W];
            slc_b   = r_b[r_cnt*SLICE_W +: SLICE_W];
            slc_cin = r_carry;
        end
        w_sum_nxt[r_cnt*SLICE_W +: SLICE_W] = slc_sum;
    end

    // Next-state logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, per-slice accumulation and result hold registers.
    // The result registers are separate from the working sum so they stay
    // stable after the handshake while the next operation is computing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_prio     <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_id       <= 1'b0;
            r_sum      <= '0;
            r_res_sum  <= '0;
            r_res_cout <= 1'b0;
            r_res_id   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_acc) begin
                r_a     <= w_gnt ? req1_a   : req0_a;
                r_b     <= w_gnt ? req1_b   : req0_b;
                r_carry <= w_gnt ? req1_cin : req0_cin;
                r_id    <= w_gnt;
                r_prio  <= ~w_gnt;
                r_cnt   <= '0;
            end
        end else if (r_state == S_RUN) begin
            r_sum   <= w_sum_nxt;
            r_carry <= slc_cout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_res_sum  <= w_sum_nxt;
                r_res_cout <= slc_cout;
                r_res_id   <= r_id;
            end
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;

endmodule
